// File: rtl/npu_arb_pkg.sv
// Shared definitions for the NPU / CPU data-SRAM arbiter.
//   arb_state_e   : arbiter FSM encoding (IDLE, START, RUN, DRAIN)
//   *_DEF         : default parameter values for the arbiter
//   cpu_addr_ok() : true when a CPU byte address falls inside the SRAM
package npu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 4096;

  // A CPU byte address maps onto the SRAM only when every bit above the
  // word index (bits [31:addr_w+2]) is zero.
  function automatic logic cpu_addr_ok(input logic [31:0] addr, input int addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (hi == 32'd0);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Watchdog for the NPU ownership window.
//   clk, rst : clock, synchronous active-high reset
//   clear_i  : zero the counter (held while the NPU is not running)
//   en_i     : count one NPU run cycle
//   expire_o : high on the run cycle that brings the count to TIMEOUT
module arb_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at TIMEOUT so a late release can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT-th counted cycle, so exactly TIMEOUT run cycles
  // elapse before the arbiter forces the release.
  assign expire_o = en_i && !clear_i && (cnt_d == LIMIT);

endmodule

// File: rtl/npu_mem_arbiter.sv
// Arbitrates one single-port, sync-read data SRAM between the CPU MEM stage
// and the NPU. The CPU owns the SRAM while idle; the NPU owns it from an
// EN_NPU launch until npu_done or watchdog expiry.
//   clk, rst                         : clock, synchronous active-high reset
//   memread_c/memwrite_c/addr_c/wd_c : CPU MEM-stage access
//   R_DATA, mem_haz                  : CPU load data (registered), CPU stall
//   EN_NPU, matA/matB/matC           : NPU launch pulse and base addresses
//   acquire_npu, npu_start           : NPU ownership level, launch pulse
//   npu_mat_a/b/c                    : latched base addresses
//   npu_req/we/addr/wdata, npu_gnt   : NPU access port
//   npu_rdata, npu_rvalid            : NPU read return
//   npu_done, npu_err                : NPU completion, sticky watchdog error
//   sram_*                           : SRAM port (read data 1 cycle later)
//   dbg_state                        : current arbiter FSM state
//
// Handshakes: the CPU presents an access and keeps it (address included)
// stable for every cycle mem_haz=1; the access is complete on the first
// cycle with mem_haz=0. The NPU request is accepted in any cycle where
// npu_req && npu_gnt; an accepted read returns with npu_rvalid on the
// following cycle. Neither side may assume acceptance without the grant.
module npu_mem_arbiter
  import npu_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_c,
  input  logic              memwrite_c,
  input  logic [31:0]       addr_c,
  input  logic [DATA_W-1:0] wd_c,
  output logic [DATA_W-1:0] R_DATA,
  output logic              mem_haz,
  input  logic              EN_NPU,
  input  logic [ADDR_W-1:0] matA,
  input  logic [ADDR_W-1:0] matB,
  input  logic [ADDR_W-1:0] matC,
  output logic              acquire_npu,
  output logic              npu_start,
  output logic [ADDR_W-1:0] npu_mat_a,
  output logic [ADDR_W-1:0] npu_mat_b,
  output logic [ADDR_W-1:0] npu_mat_c,
  input  logic              npu_req,
  input  logic              npu_we,
  input  logic [ADDR_W-1:0] npu_addr,
  input  logic [DATA_W-1:0] npu_wdata,
  output logic              npu_gnt,
  output logic [DATA_W-1:0] npu_rdata,
  output logic              npu_rvalid,
  input  logic              npu_done,
  output logic              npu_err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [1:0]        dbg_state
);

  arb_state_e        state_q;
  logic              acq_q;
  logic              start_q;
  logic              err_q;
  logic              launch_pend_q;
  logic              load_pend_q;
  logic              load_ok_q;
  logic              npu_rv_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] mat_a_q;
  logic [ADDR_W-1:0] mat_b_q;
  logic [ADDR_W-1:0] mat_c_q;

  logic              st_idle;
  logic              st_run;
  logic              cpu_ok;
  logic [ADDR_W-1:0] cpu_word;
  logic              cpu_store;
  logic              cpu_load_issue;
  logic              go_start;
  logic              wd_expire;

  assign st_idle  = (state_q == IDLE);
  assign st_run   = (state_q == RUN);
  assign cpu_ok   = cpu_addr_ok(addr_c, ADDR_W);
  assign cpu_word = addr_c[ADDR_W+1:2];

  // A store wins when both strobes are set. A load only issues on its first
  // cycle; the following cycle (load_pend_q) is the retire cycle, during
  // which the CPU still holds memread_c but no new read is issued.
  assign cpu_store      = st_idle && memwrite_c;
  assign cpu_load_issue = st_idle && memread_c && !memwrite_c && !load_pend_q;

  // A launch waits only for a load that is issuing this cycle; a store
  // completes in its own cycle and a retiring load no longer needs the SRAM.
  assign go_start = st_idle && (EN_NPU || launch_pend_q) && !cpu_load_issue;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!st_run),
    .en_i     (st_run),
    .expire_o (wd_expire)
  );

  // CPU stall: a load stalls for its issue cycle while idle; any access
  // stalls for as long as the NPU holds the SRAM.
  always_comb begin
    mem_haz = 1'b0;
    if (st_idle) begin
      mem_haz = cpu_load_issue;
    end else begin
      mem_haz = memread_c || memwrite_c;
    end
  end

  // SRAM port mux. Out-of-range CPU accesses never reach the SRAM.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    npu_gnt    = 1'b0;
    if (st_run) begin
      npu_gnt = npu_req;
      if (npu_req) begin
        sram_en    = 1'b1;
        sram_we    = npu_we;
        sram_addr  = npu_addr;
        sram_wdata = npu_wdata;
      end
    end else if (st_idle && cpu_ok) begin
      if (cpu_store) begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = cpu_word;
        sram_wdata = wd_c;
      end else if (cpu_load_issue) begin
        sram_en   = 1'b1;
        sram_addr = cpu_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acq_q         <= 1'b0;
      start_q       <= 1'b0;
      err_q         <= 1'b0;
      launch_pend_q <= 1'b0;
      load_pend_q   <= 1'b0;
      load_ok_q     <= 1'b0;
      npu_rv_q      <= 1'b0;
      rdata_q       <= '0;
      mat_a_q       <= '0;
      mat_b_q       <= '0;
      mat_c_q       <= '0;
    end else begin
      start_q     <= 1'b0;
      npu_rv_q    <= st_run && npu_req && !npu_we;
      load_pend_q <= cpu_load_issue;
      load_ok_q   <= cpu_ok;
      if (load_pend_q) begin
        rdata_q <= load_ok_q ? sram_rdata : '0;
      end

      case (state_q)
        IDLE: begin
          if (EN_NPU) begin
            mat_a_q <= matA;
            mat_b_q <= matB;
            mat_c_q <= matC;
          end
          if (go_start) begin
            state_q       <= START;
            start_q       <= 1'b1;
            acq_q         <= 1'b1;
            launch_pend_q <= 1'b0;
          end else if (EN_NPU) begin
            launch_pend_q <= 1'b1;
          end
        end
        START: begin
          state_q <= npu_done ? DRAIN : RUN;
        end
        RUN: begin
          // Completion takes priority over a same-cycle watchdog expiry.
          if (npu_done) begin
            state_q <= DRAIN;
          end else if (wd_expire) begin
            err_q   <= 1'b1;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          acq_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          acq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign R_DATA      = rdata_q;
  assign acquire_npu = acq_q;
  assign npu_start   = start_q;
  assign npu_mat_a   = mat_a_q;
  assign npu_mat_b   = mat_b_q;
  assign npu_mat_c   = mat_c_q;
  assign npu_err     = err_q;
  assign npu_rvalid  = npu_rv_q;
  assign npu_rdata   = npu_rv_q ? sram_rdata : '0;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_npu_mem_arbiter.sv
module tb_npu_mem_arbiter;
  import npu_arb_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              memread_c, memwrite_c;
  logic [31:0]       addr_c;
  logic [DATA_W-1:0] wd_c;
  logic [DATA_W-1:0] R_DATA;
  logic              mem_haz;
  logic              EN_NPU;
  logic [ADDR_W-1:0] matA, matB, matC;
  logic              acquire_npu, npu_start;
  logic [ADDR_W-1:0] npu_mat_a, npu_mat_b, npu_mat_c;
  logic              npu_req, npu_we;
  logic [ADDR_W-1:0] npu_addr;
  logic [DATA_W-1:0] npu_wdata;
  logic              npu_gnt;
  logic [DATA_W-1:0] npu_rdata;
  logic              npu_rvalid;
  logic              npu_done;
  logic              npu_err;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] npu_q[$];
  logic [DATA_W-1:0] got;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  npu_mem_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst),
    .memread_c (memread_c), .memwrite_c (memwrite_c), .addr_c (addr_c), .wd_c (wd_c),
    .R_DATA (R_DATA), .mem_haz (mem_haz),
    .EN_NPU (EN_NPU), .matA (matA), .matB (matB), .matC (matC),
    .acquire_npu (acquire_npu), .npu_start (npu_start),
    .npu_mat_a (npu_mat_a), .npu_mat_b (npu_mat_b), .npu_mat_c (npu_mat_c),
    .npu_req (npu_req), .npu_we (npu_we), .npu_addr (npu_addr), .npu_wdata (npu_wdata),
    .npu_gnt (npu_gnt), .npu_rdata (npu_rdata), .npu_rvalid (npu_rvalid),
    .npu_done (npu_done), .npu_err (npu_err),
    .sram_en (sram_en), .sram_we (sram_we), .sram_addr (sram_addr),
    .sram_wdata (sram_wdata), .sram_rdata (sram_rdata),
    .dbg_state (dbg_state)
  );

  // Single-port sync-read SRAM model.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    memread_c = 1'b0; memwrite_c = 1'b0; addr_c = '0; wd_c = '0;
    EN_NPU = 1'b0; matA = '0; matB = '0; matC = '0;
    npu_req = 1'b0; npu_we = 1'b0; npu_addr = '0; npu_wdata = '0; npu_done = 1'b0;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                        input logic [ADDR_W-1:0] c);
    nxt; EN_NPU = 1'b1; matA = a; matB = b; matC = c;
    @(negedge clk);
    nxt; EN_NPU = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [DATA_W-1:0] d,
                           input logic both, input logic in_range, input string nm);
    nxt; memwrite_c = 1'b1; memread_c = both; addr_c = a; wd_c = d;
    @(negedge clk);
    checks++;
    if (mem_haz !== 1'b0) begin errors++; $display("FAIL %s_haz: got %0b want 0", nm, mem_haz); end
    checks++;
    if ((sram_en && sram_we) !== in_range) begin
      errors++; $display("FAIL %s_sram_write: got %0b want %0b", nm, sram_en && sram_we, in_range);
    end
    nxt; memwrite_c = 1'b0; memread_c = 1'b0;
  endtask

  task automatic cpu_load(input logic [31:0] a, input logic [DATA_W-1:0] expv,
                          input logic in_range, input string nm);
    nxt; memread_c = 1'b1; addr_c = a; exp_q.push_back(expv);
    @(negedge clk);
    checks++;
    if (mem_haz !== 1'b1) begin errors++; $display("FAIL %s_haz_issue: got %0b want 1", nm, mem_haz); end
    checks++;
    if (sram_en !== in_range) begin errors++; $display("FAIL %s_sram_en: got %0b want %0b", nm, sram_en, in_range); end
    nxt;
    @(negedge clk);
    checks++;
    if (mem_haz !== 1'b0) begin errors++; $display("FAIL %s_haz_retire: got %0b want 0", nm, mem_haz); end
    nxt; memread_c = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s_rdata: got empty queue want entry", nm);
    end else begin
      got = exp_q.pop_front();
      if (R_DATA !== got) begin errors++; $display("FAIL %s_rdata: got %h want %h", nm, R_DATA, got); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle_inputs(); rst = 1'b1;
    nxt; nxt; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({R_DATA, mem_haz, acquire_npu, npu_start, npu_err, npu_rvalid, sram_en} !== '0) begin
      errors++; $display("FAIL reset_outputs: got rdata=%h haz=%0b acq=%0b start=%0b err=%0b rv=%0b en=%0b want all 0",
                         R_DATA, mem_haz, acquire_npu, npu_start, npu_err, npu_rvalid, sram_en);
    end
    checks++;
    if ({npu_mat_a, npu_mat_b, npu_mat_c, dbg_state} !== '0) begin
      errors++; $display("FAIL reset_mats_state: got %h %h %h st=%0d want 0", npu_mat_a, npu_mat_b, npu_mat_c, dbg_state);
    end
  endtask

  task automatic test_store_load;
    cpu_store(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, "store10");
    cpu_store(32'h20, 32'hA5A5A5A5, 1'b1, 1'b1, "store_both");
    cpu_store(32'h100, 32'hCAFE0040, 1'b0, 1'b1, "store100");
    cpu_load(32'h10, 32'hDEADBEEF, 1'b1, "load10");
    cpu_load(32'h20, 32'hA5A5A5A5, 1'b1, "load20");
  endtask

  task automatic test_npu_run;
    nxt; EN_NPU = 1'b1; matA = 10'h040; matB = 10'h080; matC = 10'h0C0;
    @(negedge clk);
    checks++;
    if ({npu_start, acquire_npu} !== 2'b00) begin errors++; $display("FAIL launch_early: got %b want 00", {npu_start, acquire_npu}); end
    nxt; EN_NPU = 1'b0; matA = '0; matB = '0; matC = '0;
    @(negedge clk);
    checks++;
    if ({npu_start, acquire_npu, dbg_state} !== {2'b11, 2'(START)}) begin
      errors++; $display("FAIL launch_start: got start=%0b acq=%0b st=%0d want 1 1 1", npu_start, acquire_npu, dbg_state);
    end
    checks++;
    if ({npu_mat_a, npu_mat_b, npu_mat_c} !== {10'h040, 10'h080, 10'h0C0}) begin
      errors++; $display("FAIL launch_mats: got %h %h %h want 040 080 0c0", npu_mat_a, npu_mat_b, npu_mat_c);
    end
    // RUN: CPU load collides with an NPU read of 0x040.
    nxt; memread_c = 1'b1; addr_c = 32'h10; npu_req = 1'b1; npu_we = 1'b0; npu_addr = 10'h040;
    npu_q.push_back(32'hCAFE0040);
    @(negedge clk);
    checks++;
    if ({npu_start, mem_haz, npu_gnt, sram_en, sram_we} !== 5'b01110 || sram_addr !== 10'h040) begin
      errors++; $display("FAIL run_read: got start=%0b haz=%0b gnt=%0b en=%0b we=%0b addr=%h want 0 1 1 1 0 040",
                         npu_start, mem_haz, npu_gnt, sram_en, sram_we, sram_addr);
    end
    nxt; npu_we = 1'b1; npu_addr = 10'h041; npu_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (npu_rvalid !== 1'b1 || npu_q.size() == 0) begin
      errors++; $display("FAIL run_rvalid: got %0b want 1", npu_rvalid);
    end else begin
      got = npu_q.pop_front();
      if (npu_rdata !== got) begin errors++; $display("FAIL run_rdata: got %h want %h", npu_rdata, got); end
    end
    checks++;
    if ({mem_haz, sram_we} !== 2'b11) begin errors++; $display("FAIL run_write: got haz/we %b want 11", {mem_haz, sram_we}); end
    nxt; npu_req = 1'b0; npu_we = 1'b0; npu_done = 1'b1;
    @(negedge clk);
    checks++;
    if (npu_rvalid !== 1'b0) begin errors++; $display("FAIL run_no_rvalid_after_write: got %0b want 0", npu_rvalid); end
    nxt; npu_done = 1'b0; npu_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbg_state, acquire_npu, npu_gnt, sram_en, mem_haz} !== {2'(DRAIN), 4'b1001}) begin
      errors++; $display("FAIL drain: got st=%0d acq=%0b gnt=%0b en=%0b haz=%0b want 3 1 0 0 1",
                         dbg_state, acquire_npu, npu_gnt, sram_en, mem_haz);
    end
    nxt; npu_req = 1'b0; exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({dbg_state, acquire_npu, mem_haz, sram_en} !== {2'(IDLE), 3'b011}) begin
      errors++; $display("FAIL back_idle: got st=%0d acq=%0b haz=%0b en=%0b want 0 0 1 1", dbg_state, acquire_npu, mem_haz, sram_en);
    end
    nxt;
    @(negedge clk);
    checks++;
    if (mem_haz !== 1'b0) begin errors++; $display("FAIL held_load_retire: got %0b want 0", mem_haz); end
    nxt; memread_c = 1'b0;
    @(negedge clk);
    checks++;
    got = exp_q.pop_front();
    if (R_DATA !== got) begin errors++; $display("FAIL held_load_rdata: got %h want %h", R_DATA, got); end
    cpu_load(32'h104, 32'h12345678, 1'b1, "load_npu_written");
  endtask

  task automatic test_done_vs_timeout;
    launch(10'h001, 10'h002, 10'h003);
    for (int k = 1; k <= TIMEOUT; k++) begin
      nxt; npu_done = (k == TIMEOUT);
      @(negedge clk);
    end
    nxt; npu_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_state, npu_err} !== {2'(DRAIN), 1'b0}) begin
      errors++; $display("FAIL done_wins: got st=%0d err=%0b want 3 0", dbg_state, npu_err);
    end
    nxt;
  endtask

  task automatic test_en_with_load;
    nxt; memread_c = 1'b1; addr_c = 32'h10; EN_NPU = 1'b1; matA = 10'h011; matB = 10'h022; matC = 10'h033;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({mem_haz, sram_en, sram_we} !== 3'b110 || sram_addr !== 10'h004) begin
      errors++; $display("FAIL enload_issue: got haz=%0b en=%0b we=%0b addr=%h want 1 1 0 004", mem_haz, sram_en, sram_we, sram_addr);
    end
    nxt; EN_NPU = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_haz, sram_en, npu_start, dbg_state} !== {3'b000, 2'(IDLE)}) begin
      errors++; $display("FAIL enload_retire: got haz=%0b en=%0b start=%0b st=%0d want 0 0 0 0", mem_haz, sram_en, npu_start, dbg_state);
    end
    nxt; memread_c = 1'b0;
    @(negedge clk);
    checks++;
    got = exp_q.pop_front();
    if (R_DATA !== got) begin errors++; $display("FAIL enload_rdata: got %h want %h", R_DATA, got); end
    checks++;
    if ({npu_start, npu_mat_a, npu_mat_c} !== {1'b1, 10'h011, 10'h033}) begin
      errors++; $display("FAIL enload_start: got start=%0b a=%h c=%h want 1 011 033", npu_start, npu_mat_a, npu_mat_c);
    end
    nxt; npu_done = 1'b1;
    @(negedge clk);
    nxt; npu_done = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'(DRAIN)) begin errors++; $display("FAIL enload_drain: got %0d want 3", dbg_state); end
    nxt;
  endtask

  task automatic test_oob;
    cpu_store(32'h1010, 32'h11111111, 1'b0, 1'b0, "oob_store");
    cpu_load(32'h1000, 32'h0, 1'b0, "oob_load");
    cpu_load(32'h10, 32'hDEADBEEF, 1'b1, "after_oob_load");
  endtask

  task automatic test_watchdog;
    int run_cycles;
    logic left_run;
    run_cycles = 0;
    left_run = 1'b0;
    launch(10'h005, 10'h006, 10'h007);
    for (int k = 0; k < 64 && !left_run; k++) begin
      nxt;
      @(negedge clk);
      if (dbg_state == 2'(RUN)) run_cycles++;
      else left_run = 1'b1;
    end
    checks++;
    if (!left_run || run_cycles != TIMEOUT) begin
      errors++; $display("FAIL wd_run_cycles: got %0d (left=%0b) want %0d", run_cycles, left_run, TIMEOUT);
    end
    checks++;
    if ({dbg_state, npu_err} !== {2'(DRAIN), 1'b1}) begin
      errors++; $display("FAIL wd_err: got st=%0d err=%0b want 3 1", dbg_state, npu_err);
    end
    nxt;
    @(negedge clk);
    checks++;
    if ({dbg_state, acquire_npu} !== {2'(IDLE), 1'b0}) begin
      errors++; $display("FAIL wd_idle: got st=%0d acq=%0b want 0 0", dbg_state, acquire_npu);
    end
    cpu_load(32'h20, 32'hA5A5A5A5, 1'b1, "wd_after_load");
    checks++;
    if (npu_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %0b want 1", npu_err); end
  endtask

  task automatic test_reset_mid_run;
    launch(10'h008, 10'h009, 10'h00A);
    nxt; npu_req = 1'b1; npu_we = 1'b0; npu_addr = 10'h040; rst = 1'b1;
    @(negedge clk);
    nxt; rst = 1'b0; npu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({R_DATA, npu_rdata, mem_haz, acquire_npu, npu_start, npu_err, npu_rvalid, npu_gnt, sram_en} !== '0) begin
      errors++; $display("FAIL midrun_reset: got rdata=%h nrdata=%h haz=%0b acq=%0b start=%0b err=%0b rv=%0b gnt=%0b en=%0b want all 0",
                         R_DATA, npu_rdata, mem_haz, acquire_npu, npu_start, npu_err, npu_rvalid, npu_gnt, sram_en);
    end
    checks++;
    if ({npu_mat_a, npu_mat_b, npu_mat_c, dbg_state} !== '0) begin
      errors++; $display("FAIL midrun_reset_mats: got %h %h %h st=%0d want 0", npu_mat_a, npu_mat_b, npu_mat_c, dbg_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom_range(32'hFFFF, 0);
    test_reset();
    test_store_load();
    test_npu_run();
    test_done_vs_timeout();
    test_en_with_load();
    test_oob();
    test_watchdog();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
